// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: one shift-add or restoring-division step per cycle.
// Signed operations run on magnitudes and the sign is corrected in the DONE cycle.
module mdu_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               div_zero_o,
  output logic               stallreq_o
);

  localparam int unsigned W2 = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic [W2-1:0]    result_q, result_d;

  // Operand capture: magnitudes of signed operands (most-negative value maps onto itself)
  logic             is_signed, neg1, neg2, div_by_zero;
  logic [WIDTH-1:0] mag1, mag2;

  assign is_signed   = ~op_i[0];
  assign neg1        = is_signed & opdata1_i[WIDTH-1];
  assign neg2        = is_signed & opdata2_i[WIDTH-1];
  assign mag1        = neg1 ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
  assign mag2        = neg2 ? (~opdata2_i + WIDTH'(1)) : opdata2_i;
  assign div_by_zero = op_i[1] & (opdata2_i == '0);

  // Shift-add step: acc = {partial product, remaining multiplier bits}
  logic [WIDTH:0] mul_sum;
  logic [W2-1:0]  mul_next;

  assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : (WIDTH+1)'(0));
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring step: acc = {partial remainder, dividend bits / quotient bits}
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] div_diff;
  logic [W2-1:0]    div_next;

  assign rem_sh   = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = {1'b0, rem_sh} - {2'b00, opnd_q};
  assign div_next = div_diff[WIDTH+1] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  // Sign-corrected result presented in the DONE cycle
  logic [WIDTH-1:0] quot, rem;
  logic [W2-1:0]    final_res;

  assign quot = acc_q[WIDTH-1:0];
  assign rem  = acc_q[W2-1:WIDTH];

  always_comb begin
    final_res = acc_q;
    if (!dz_q) begin
      if (is_div_q) begin
        final_res = {(neg_rem_q ? (~rem + WIDTH'(1)) : rem),
                     (neg_q ? (~quot + WIDTH'(1)) : quot)};
      end else if (neg_q) begin
        final_res = ~acc_q + W2'(1);
      end
    end
  end

  assign busy_o     = (state_q != S_IDLE);
  assign ready_o    = (state_q == S_DONE) & ~annul_i;
  assign div_zero_o = ready_o & dz_q;
  assign stallreq_o = ((state_q == S_IDLE) & start_i & ~annul_i) | (state_q == S_CALC);
  assign result_o   = ready_o ? final_res : result_q;

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    result_d  = result_q;

    case (state_q)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          state_d   = S_CALC;
          is_div_d  = op_i[1];
          neg_d     = neg1 ^ neg2;
          neg_rem_d = neg1;
          dz_d      = div_by_zero;
          if (div_by_zero) begin
            // A single frozen pass through CALC, result preloaded
            cnt_d  = CNT_W'(1);
            acc_d  = {opdata1_i, {WIDTH{1'b1}}};
            opnd_d = '0;
          end else begin
            cnt_d  = CNT_W'(WIDTH);
            acc_d  = {WIDTH'(0), (op_i[1] ? mag1 : mag2)};
            opnd_d = op_i[1] ? mag2 : mag1;
          end
        end
      end
      S_CALC: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (!dz_q) acc_d = is_div_q ? div_next : mul_next;
          if (cnt_q == CNT_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (ready_o) result_d = final_res;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: directed corner cases plus random operations against an
// arithmetic reference model; a second WIDTH=8 instance covers the narrow build.
module tb_mdu_iter;

  localparam int unsigned W = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, annul;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, ready, dz, stall;
  logic [63:0] res;

  logic        start8, annul8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, ready8, dz8, stall8;
  logic [15:0] res8;

  int          tests = 0;
  int          fails = 0;
  logic [63:0] last_res;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .opdata1_i(a), .opdata2_i(b),
    .annul_i(annul), .busy_o(busy), .ready_o(ready), .result_o(res),
    .div_zero_o(dz), .stallreq_o(stall)
  );

  mdu_iter #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst(rst), .start_i(start8), .op_i(op8), .opdata1_i(a8), .opdata2_i(b8),
    .annul_i(annul8), .busy_o(busy8), .ready_o(ready8), .result_o(res8),
    .div_zero_o(dz8), .stallreq_o(stall8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {div_zero, result} straight from integer arithmetic
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] ux, uy, uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'h0, x};
    uy = {32'h0, y};
    case (o)
      2'b00: return {1'b0, 64'(sx * sy)};
      2'b01: return {1'b0, ux * uy};
      2'b10: begin
        if (y == 32'h0) return {1'b1, x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {1'b0, 32'h0, 32'h8000_0000};
        q = sx / sy;
        r = sx % sy;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (y == 32'h0) return {1'b1, x, 32'hFFFF_FFFF};
        uq = ux / uy;
        ur = ux % uy;
        return {1'b0, ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  // Start an operation at a falling edge (cycle t) and follow it to ready_o
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit hold);
    logic [64:0] m;
    int lat;
    bit seen;
    m    = model(o, x, y);
    lat  = (o[1] && y == 32'h0) ? 2 : W + 1;
    op   = o;
    a    = x;
    b    = y;
    start = 1'b1;
    #1;
    check("stall_at_start", 64'(stall), 64'(1));
    seen = 1'b0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (!hold) start = 1'b0;
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
      #1;
      if (ready) begin
        seen = 1'b1;
        check("latency", 64'(k), 64'(lat));
        check("result", res, m[63:0]);
        check("div_zero", 64'(dz), 64'(m[64]));
        check("stall_in_done", 64'(stall), 64'(0));
      end
    end
    if (!seen) check("ready_timeout", 64'(0), 64'(1));
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("result_hold", res, m[63:0]);
    check("ready_low_after", 64'(ready), 64'(0));
    check("busy_low_after", 64'(busy), 64'(0));
    last_res = m[63:0];
  endtask

  // Narrow instance: unsigned ops, stallreq checked every cycle
  task automatic do_op8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    logic [15:0] e;
    int lat;
    bit seen;
    if (o == 2'b01) e = 16'(x) * 16'(y);
    else if (y == 8'h0) e = {x, 8'hFF};
    else e = {8'(x % y), 8'(x / y)};
    lat = (o == 2'b11 && y == 8'h0) ? 2 : 9;
    op8 = o;
    a8 = x;
    b8 = y;
    start8 = 1'b1;
    #1;
    check("w8_stall_t", 64'(stall8), 64'(1));
    seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      #1;
      check("w8_stall", 64'(stall8), 64'(k < lat));
      if (ready8) begin
        seen = 1'b1;
        check("w8_latency", 64'(k), 64'(lat));
        check("w8_result", 64'(res8), 64'(e));
      end
    end
    if (!seen) check("w8_timeout", 64'(0), 64'(1));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    bit          seen_ready;

    rst = 1'b1;
    start = 1'b0; annul = 1'b0; op = 2'b00; a = '0; b = '0;
    start8 = 1'b0; annul8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
    last_res = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ready", 64'(ready), 64'(0));
    check("rst_div_zero", 64'(dz), 64'(0));
    check("rst_stall", 64'(stall), 64'(0));
    check("rst_result", res, 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Start on the very first edge after reset release
    do_op(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
    do_op(2'b11, 32'd100, 32'd7, 1'b0);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op(2'b11, 32'd5, 32'd0, 1'b0);
    do_op(2'b10, 32'h8765_4321, 32'd0, 1'b0);
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    // Annul mid-multiply: no ready, result untouched, next op fine
    op = 2'b01; a = $urandom; b = $urandom; start = 1'b1;
    seen_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (k == 10) annul = 1'b1;
      #1;
      if (ready) seen_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    annul = 1'b0;
    #1;
    if (ready) seen_ready = 1'b1;
    check("annul_no_ready", 64'(seen_ready), 64'(0));
    check("annul_idle", 64'(busy), 64'(0));
    check("annul_result_kept", res, last_res);
    @(posedge clk);
    @(negedge clk);
    do_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);

    // Annul together with start in IDLE
    start = 1'b1; annul = 1'b1;
    #1;
    check("annul_start_stall", 64'(stall), 64'(0));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    #1;
    check("annul_start_ignored", 64'(busy), 64'(0));
    @(negedge clk);

    // start_i held through CALC/DONE: exactly one operation
    do_op(2'b00, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1);

    // Randomised operations with biased corner operands
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom);
      ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'h1;
        3: rb = $urandom_range(1, 255);
        default: rb = $urandom;
      endcase
      do_op(ro, ra, rb, 1'b0);
    end

    // Asynchronous reset between edges in the middle of CALC
    op = 2'b10; a = 32'h7FFF_0001; b = 32'h0000_0013; start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_busy", 64'(busy), 64'(0));
    check("async_rst_result", res, 64'(0));
    check("async_rst_ready", 64'(ready), 64'(0));
    check("async_rst_stall", 64'(stall), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    do_op(2'b11, 32'hFFFF_FFF0, 32'h0000_0010, 1'b0);

    // Narrow build
    do_op8(2'b01, 8'hFF, 8'hFF);
    do_op8(2'b11, 8'd200, 8'd0);
    for (int i = 0; i < 6; i++) begin
      do_op8($urandom_range(0, 1) == 1 ? 2'b01 : 2'b11, 8'($urandom), 8'($urandom_range(0, 40)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
